cpu_control: RTL
================

// Module: cpu_control
// PURPOSE
//  Multicycle control FSM for the LC-3b datapath: fetch, decode and execute of ADD, AND, NOT, LDR, STR, BR.
//  Drives every datapath load/select/aluop signal and the memory read/write handshake.
//  Sits beside the datapath in the cpu top; sole owner of the memory port; has a memory-wait timeout and a retire counter.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_resp before abort; 0 = no timeout
//  RETIRE_W     16  width of retired-instruction counter
// PORTS
//  clk             in   1         clock, rising edge
//  rst_n           in   1         reset, asynchronous, active-low
//  opcode          in   4         lc3b_opcode from IR
//  branch_enable   in   1         nzp match from cccomp
//  mem_resp        in   1         memory done (read data valid / write accepted)
//  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc   out 1 each   register loads
//  pcmux_sel       out  1         0=PC+2, 1=PC+adj9
//  storemux_sel    out  1         0=sr1 field, 1=dest field onto regfile port A
//  alumux_sel      out  1         0=sr2_out, 1=adj6
//  regfilemux_sel  out  1         0=alu_out, 1=MDR
//  marmux_sel      out  1         0=alu_out, 1=PC
//  mdrmux_sel      out  1         0=alu_out, 1=mem_rdata
//  aluop           out  lc3b_aluop
//  mem_read        out  1         read request, held until mem_resp
//  mem_write       out  1         write request, held until mem_resp
//  mem_byte_enable out  2         always 2'b11
//  mem_err         out  1         1-cycle pulse on timeout abort
//  retired         out  RETIRE_W  instructions completed, wraps modulo 2^RETIRE_W
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. rst_n low: state<=FETCH1, wait counter<=0, retired<=0, mem_err<=0.
//    Reset mid-access drops mem_read/mem_write in the same cycle (outputs decoded from state).
//  - Moore outputs. Defaults in all states: all loads/sels/mem_* = 0, aluop=alu_add, mem_byte_enable=2'b11.
//  - States and asserted signals:
//    FETCH1    marmux_sel=1, load_mar, load_pc (PC+2)                -> FETCH2
//    FETCH2    mem_read, mdrmux_sel=1, load_mdr; hold till mem_resp  -> FETCH3
//    FETCH3    load_ir                                               -> DECODE
//    DECODE    none; ADD/AND/NOT->own state, LDR/STR->CALC_ADDR, BR->BR; any other opcode -> FETCH1, no retire
//    ADD/AND/NOT  aluop=add/and/not, alumux_sel=0, regfilemux_sel=0, load_regfile, load_cc -> FETCH1
//    CALC_ADDR alumux_sel=1, aluop=add, marmux_sel=0, load_mar       -> LDR1 | STR1
//    LDR1      mem_read, mdrmux_sel=1, load_mdr; hold till mem_resp  -> LDR2
//    LDR2      regfilemux_sel=1, load_regfile, load_cc               -> FETCH1
//    STR1      storemux_sel=1, aluop=pass, mdrmux_sel=0, load_mdr    -> STR2
//    STR2      mem_write; hold till mem_resp                         -> FETCH1
//    BR        branch_enable ? BR_TAKEN : FETCH1
//    BR_TAKEN  pcmux_sel=1, load_pc                                  -> FETCH1
//  - Memory wait states hold load_mdr asserted; the final load coincides with mem_resp, so MDR holds the valid data.
//    Minimum wait: 1 cycle (mem_resp in the first cycle of the state).
//  - Timeout: the wait counter clears on entry to FETCH2/LDR1/STR2 and increments each wait cycle without mem_resp.
//    When it reaches MEM_TIMEOUT: abort to FETCH1, pulse mem_err, no retire, no regfile/cc write.
//    mem_resp in the same cycle as the timeout: the response wins.
//  - retired increments on leaving ADD/AND/NOT/LDR2/STR2/BR(not taken)/BR_TAKEN toward FETCH1.
//  - mem_resp outside a wait state is ignored.
// STRUCTURE
//  - lc3b_types (shared package): lc3b_opcode, lc3b_aluop (add,and,not,pass).
//  - State enum is local to this module.
//  - Sub-module mem_wait_timer: clear/enable/expired counter, width $clog2(MEM_TIMEOUT+1).
// TESTING
//  - ADD R3,R1,R2, mem_resp 1 cycle -> FETCH1..3,DECODE,ADD = 5 cycles; load_regfile+load_cc 1 cycle; retired 0->1.
//  - LDR, mem_resp after 3 cycles in LDR1 -> mem_read high exactly 3 cycles; LDR2 load_regfile, regfilemux_sel=1.
//  - STR -> STR1 storemux_sel=1, aluop=pass, load_mdr; STR2 mem_write held until mem_resp; never load_regfile.
//  - BR with branch_enable=1 -> BR_TAKEN pcmux_sel=1, load_pc; branch_enable=0 -> FETCH1 next cycle; retired +1 each.
//  - MEM_TIMEOUT=4, mem_resp never -> FETCH2 4 cycles, mem_err pulse, FETCH1; retired unchanged.
//  - rst_n low in the 2nd FETCH2 cycle -> mem_read 0 the same cycle; after release, FETCH1 with retired=0.
//  - Illegal opcode (e.g. 4'b1101) -> DECODE->FETCH1, no loads, retired unchanged.

Source files
------------

// File: rtl/cpu_control_pkg.sv
// lc3b_types: shared LC-3b opcode and ALU operation encodings
// Ports: none (package)
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        alu_add  = 2'b00,
        alu_and  = 2'b01,
        alu_not  = 2'b10,
        alu_pass = 2'b11
    } lc3b_aluop;

endpackage

// File: rtl/cpu_control_mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags the cycle that would hit the timeout
// Ports: clk, rst_n (async active-low), i_clr (zero the count), i_en (count one wait cycle),
//        o_expired (this wait cycle is the last one allowed; never set when MEM_TIMEOUT is 0)
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + W'(1);
    end

    // Flag the cycle whose missing response would bring the count to MEM_TIMEOUT,
    // so the FSM leaves after exactly MEM_TIMEOUT wait cycles.
    assign o_expired = (MEM_TIMEOUT != 0) && (r_count == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_control.sv
// cpu_control: multicycle LC-3b control FSM (fetch/decode/execute of ADD, AND, NOT, LDR, STR, BR)
// Ports: clk, rst_n (async active-low); opcode, branch_enable, mem_resp in;
//        datapath loads/selects/aluop, mem_read/mem_write/mem_byte_enable out;
//        mem_err (1-cycle pulse after a timeout abort), retired (completed-instruction count)
module cpu_control
    import lc3b_types::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  lc3b_opcode          opcode,
    input  logic                branch_enable,
    input  logic                mem_resp,
    output logic                load_pc,
    output logic                load_ir,
    output logic                load_regfile,
    output logic                load_mar,
    output logic                load_mdr,
    output logic                load_cc,
    output logic                pcmux_sel,
    output logic                storemux_sel,
    output logic                alumux_sel,
    output logic                regfilemux_sel,
    output logic                marmux_sel,
    output logic                mdrmux_sel,
    output lc3b_aluop           aluop,
    output logic                mem_read,
    output logic                mem_write,
    output logic [1:0]          mem_byte_enable,
    output logic                mem_err,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [3:0] FETCH1    = 4'd0;
    localparam logic [3:0] FETCH2    = 4'd1;
    localparam logic [3:0] FETCH3    = 4'd2;
    localparam logic [3:0] DECODE    = 4'd3;
    localparam logic [3:0] S_ADD     = 4'd4;
    localparam logic [3:0] S_AND     = 4'd5;
    localparam logic [3:0] S_NOT     = 4'd6;
    localparam logic [3:0] CALC_ADDR = 4'd7;
    localparam logic [3:0] LDR1      = 4'd8;
    localparam logic [3:0] LDR2      = 4'd9;
    localparam logic [3:0] STR1      = 4'd10;
    localparam logic [3:0] STR2      = 4'd11;
    localparam logic [3:0] S_BR      = 4'd12;
    localparam logic [3:0] BR_TAKEN  = 4'd13;

    logic [3:0]          r_state;
    logic [3:0]          w_next;
    logic                w_wait;
    logic                w_expired;
    logic                w_retire;
    logic [RETIRE_W-1:0] r_retired;
    logic                r_mem_err;

    assign w_wait = (r_state == FETCH2) || (r_state == LDR1) || (r_state == STR2);

    // Held at zero outside the wait states, so every wait state starts counting from 0.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (!w_wait),
        .i_en      (w_wait && !mem_resp),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH1:    w_next = FETCH2;
            FETCH2:    w_next = mem_resp ? FETCH3 : (w_expired ? FETCH1 : FETCH2);
            FETCH3:    w_next = DECODE;
            DECODE: begin
                case (opcode)
                    op_add:         w_next = S_ADD;
                    op_and:         w_next = S_AND;
                    op_not:         w_next = S_NOT;
                    op_ldr, op_str: w_next = CALC_ADDR;
                    op_br:          w_next = S_BR;
                    default:        w_next = FETCH1;
                endcase
            end
            CALC_ADDR: w_next = (opcode == op_ldr) ? LDR1 : STR1;
            LDR1:      w_next = mem_resp ? LDR2 : (w_expired ? FETCH1 : LDR1);
            STR1:      w_next = STR2;
            STR2:      w_next = (mem_resp || w_expired) ? FETCH1 : STR2;
            S_BR:      w_next = branch_enable ? BR_TAKEN : FETCH1;
            default:   w_next = FETCH1;
        endcase
    end

    // A timed-out STR2 leaves without mem_resp and therefore does not retire.
    assign w_retire = (r_state inside {S_ADD, S_AND, S_NOT, LDR2, BR_TAKEN})
                   || (r_state == STR2 && mem_resp)
                   || (r_state == S_BR && !branch_enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH1;
            r_retired <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_retired <= r_retired + RETIRE_W'(w_retire);
            r_mem_err <= w_wait && !mem_resp && w_expired;
        end
    end

    always_comb begin
        load_pc        = 1'b0;
        load_ir        = 1'b0;
        load_regfile   = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_cc        = 1'b0;
        pcmux_sel      = 1'b0;
        storemux_sel   = 1'b0;
        alumux_sel     = 1'b0;
        regfilemux_sel = 1'b0;
        marmux_sel     = 1'b0;
        mdrmux_sel     = 1'b0;
        aluop          = alu_add;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        case (r_state)
            FETCH1: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
                load_pc    = 1'b1;
            end
            FETCH2, LDR1: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
            end
            FETCH3:    load_ir = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                aluop        = (r_state == S_AND) ? alu_and : (r_state == S_NOT) ? alu_not : alu_add;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
            end
            CALC_ADDR: begin
                alumux_sel = 1'b1;
                load_mar   = 1'b1;
            end
            LDR2: begin
                regfilemux_sel = 1'b1;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
            end
            STR1: begin
                storemux_sel = 1'b1;
                aluop        = alu_pass;
                load_mdr     = 1'b1;
            end
            STR2:      mem_write = 1'b1;
            BR_TAKEN: begin
                pcmux_sel = 1'b1;
                load_pc   = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_byte_enable = 2'b11;
    assign mem_err         = r_mem_err;
    assign retired         = r_retired;

endmodule
